// File: rtl/da_pkg.sv
// Shared dopamine-level encodings, controller state encoding and the decay step rule.
package da_pkg;

  localparam logic [1:0] DA_NONE = 2'b00;
  localparam logic [1:0] DA_BASE = 2'b01;
  localparam logic [1:0] DA_HIGH = 2'b10;
  localparam logic [1:0] DA_MAX  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EVAL  = 2'd1,
    ST_BURST = 2'd2,
    ST_DECAY = 2'd3
  } da_state_e;

  // One decay step toward baseline: bursts step down through HIGH, dips return straight to BASE.
  function automatic logic [1:0] da_step(input logic [1:0] level);
    logic [1:0] nxt;
    case (level)
      DA_MAX:  nxt = DA_HIGH;
      DA_HIGH: nxt = DA_BASE;
      DA_NONE: nxt = DA_BASE;
      default: nxt = DA_BASE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/rpe_quantizer.sv
// Maps a signed reward-prediction error onto one of the four dopamine levels.
module rpe_quantizer
  import da_pkg::*;
#(
  parameter logic signed [8:0] TH_HIGH = 9'sd64,
  parameter logic signed [8:0] TH_LOW  = 9'sd16
) (
  input  logic signed [8:0] rpe_i,
  output logic        [1:0] lvl_o
);

  localparam logic signed [8:0] TH_NEG = -TH_LOW;

  // Strong positive surprise saturates, mild surprise is ignored, disappointment suppresses.
  always_comb begin
    lvl_o = DA_BASE;
    if (rpe_i >= TH_HIGH) begin
      lvl_o = DA_MAX;
    end else if (rpe_i >= TH_LOW) begin
      lvl_o = DA_HIGH;
    end else if (rpe_i <= TH_NEG) begin
      lvl_o = DA_NONE;
    end
  end

endmodule

// File: rtl/dopamine_controller.sv
// Reward-prediction-error controller: tracks a running reward expectation and turns
// each surprise into a timed dopamine burst that decays back to baseline.
module dopamine_controller
  import da_pkg::*;
#(
  parameter logic        [7:0] INIT_EXPECT = 8'd0,
  parameter logic signed [8:0] TH_HIGH     = 9'sd64,
  parameter logic signed [8:0] TH_LOW      = 9'sd16,
  parameter int                ALPHA_SHIFT = 2,
  parameter int                HOLD_CYC    = 4,
  parameter int                DECAY_CYC   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       reward_valid,
  input  logic [7:0] reward,
  output logic       reward_ready,
  input  logic       expect_clr,
  output logic [1:0] dopamine_level,
  output logic [8:0] rpe,
  output logic [7:0] expected,
  output logic       busy
);

  localparam int CNT_MAX = (HOLD_CYC > DECAY_CYC) ? HOLD_CYC : DECAY_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_HOLD  = CNT_W'(HOLD_CYC);
  localparam logic [CNT_W-1:0] CNT_DECAY = CNT_W'(DECAY_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  da_state_e        state_q, state_d;
  logic [1:0]       level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [8:0]       rpe_q, rpe_d;
  logic [7:0]       expected_q, expected_d;
  logic [7:0]       reward_q, reward_d;

  logic              accept;
  logic signed [8:0] rpe_eval;
  logic signed [8:0] rpe_shift;
  logic signed [10:0] exp_sum;
  logic [7:0]        exp_sat;
  logic [1:0]        lvl_eval;
  logic [1:0]        lvl_step;

  assign reward_ready   = (state_q != ST_EVAL);
  assign accept         = reward_valid & reward_ready;
  assign busy           = (state_q != ST_IDLE);
  assign dopamine_level = level_q;
  assign rpe            = rpe_q;
  assign expected       = expected_q;

  // Both operands zero-extended so the 9-bit difference covers -255..+255 without wrap.
  assign rpe_eval  = $signed({1'b0, reward_q}) - $signed({1'b0, expected_q});
  assign rpe_shift = rpe_eval >>> ALPHA_SHIFT;
  assign exp_sum   = $signed({3'b000, expected_q}) + $signed({{2{rpe_shift[8]}}, rpe_shift});
  assign lvl_step  = da_step(level_q);

  // Clamp the expectation update into the unsigned 8-bit range.
  always_comb begin
    exp_sat = exp_sum[7:0];
    if (exp_sum < 11'sd0) begin
      exp_sat = 8'd0;
    end else if (exp_sum > 11'sd255) begin
      exp_sat = 8'd255;
    end
  end

  rpe_quantizer #(
    .TH_HIGH (TH_HIGH),
    .TH_LOW  (TH_LOW)
  ) u_quant (
    .rpe_i (rpe_eval),
    .lvl_o (lvl_eval)
  );

  // State register and datapath registers; reset parks the controller at baseline.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      level_q    <= DA_BASE;
      cnt_q      <= '0;
      rpe_q      <= '0;
      expected_q <= INIT_EXPECT;
      reward_q   <= '0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      cnt_q      <= cnt_d;
      rpe_q      <= rpe_d;
      expected_q <= expected_d;
      reward_q   <= reward_d;
    end
  end

  // Next-state logic: evaluate, hold the burst, then step down one level per decay period.
  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    cnt_d      = cnt_q;
    rpe_d      = rpe_q;
    expected_d = expected_q;
    reward_d   = reward_q;
    case (state_q)
      ST_IDLE: begin
        level_d = DA_BASE;
        if (accept) begin
          reward_d = reward;
          state_d  = ST_EVAL;
        end
      end
      ST_EVAL: begin
        rpe_d      = rpe_eval;
        expected_d = exp_sat;
        if (lvl_eval == DA_BASE) begin
          state_d = ST_IDLE;
          level_d = DA_BASE;
        end else begin
          state_d = ST_BURST;
          level_d = lvl_eval;
          cnt_d   = CNT_HOLD;
        end
      end
      ST_BURST, ST_DECAY: begin
        if (accept) begin
          // A new reward aborts the running burst; baseline is shown while it is evaluated.
          reward_d = reward;
          state_d  = ST_EVAL;
          level_d  = DA_BASE;
        end else if (cnt_q == CNT_ONE) begin
          level_d = lvl_step;
          if (lvl_step == DA_BASE) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DECAY;
            cnt_d   = CNT_DECAY;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        level_d = DA_BASE;
      end
    endcase
    // Clearing the expectation wins over any same-cycle evaluation update.
    if (expect_clr) begin
      expected_d = INIT_EXPECT;
    end
  end

endmodule

// File: tb/tb_dopamine_controller.sv
// Scoreboard bench: stimulus pushes per-cycle expectations, a negedge monitor checks them.
module tb_dopamine_controller;

  logic       clk;
  logic       rst;
  logic       reward_valid;
  logic [7:0] reward;
  logic       reward_ready;
  logic       expect_clr;
  logic [1:0] dopamine_level;
  logic [8:0] rpe;
  logic [7:0] expected;
  logic       busy;

  dopamine_controller dut (
    .clk            (clk),
    .rst            (rst),
    .reward_valid   (reward_valid),
    .reward         (reward),
    .reward_ready   (reward_ready),
    .expect_clr     (expect_clr),
    .dopamine_level (dopamine_level),
    .rpe            (rpe),
    .expected       (expected),
    .busy           (busy)
  );

  localparam int F_LVL = 0;
  localparam int F_EXP = 1;
  localparam int F_RPE = 2;
  localparam int F_RDY = 3;
  localparam int F_BSY = 4;

  typedef struct {
    int    cyc;
    int    fld;
    int    val;
    string tag;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int field_val(input int fld);
    int v;
    case (fld)
      F_LVL:   v = int'(dopamine_level);
      F_EXP:   v = int'(expected);
      F_RPE:   v = int'($signed(rpe));
      F_RDY:   v = int'(reward_ready);
      default: v = int'(busy);
    endcase
    return v;
  endfunction

  function automatic void push(input int c, input int f, input int v, input string tag);
    exp_t e;
    e.cyc = c;
    e.fld = f;
    e.val = v;
    e.tag = tag;
    sb.push_back(e);
  endfunction

  // Monitor: compare every entry due this cycle, flag any entry whose cycle slipped past.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        int act;
        act = field_val(sb[i].fld);
        n_cmp++;
        if (sb[i].cyc < cyc) begin
          n_bad++;
          $display("FAIL %s stale check at cyc=%0d (due %0d)", sb[i].tag, cyc, sb[i].cyc);
        end else if (act != sb[i].val) begin
          n_bad++;
          $display("FAIL %s cyc=%0d got=%0d want=%0d", sb[i].tag, cyc, act, sb[i].val);
        end else begin
          $display("check %s cyc=%0d value=%0d ok", sb[i].tag, cyc, act);
        end
        sb.delete(i);
      end
    end
  end

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one reward for a single cycle; optionally assert expect_clr during its EVAL cycle.
  task automatic send(input logic [7:0] val, input logic clr_at_eval, output int t);
    t = cyc;
    reward_valid = 1'b1;
    reward       = val;
    goto(t + 1);
    reward_valid = 1'b0;
    expect_clr   = clr_at_eval;
    goto(t + 2);
    expect_clr   = 1'b0;
  endtask

  task automatic push_lvl(input int from, input int to, input int v, input string tag);
    for (int c = from; c <= to; c++) push(c, F_LVL, v, tag);
  endtask

  initial begin
    int t;
    int t2;
    rst          = 1'b1;
    reward_valid = 1'b0;
    reward       = 8'd0;
    expect_clr   = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    push(cyc, F_LVL, 1, "rst_level");
    push(cyc, F_EXP, 0, "rst_expected");
    push(cyc, F_RPE, 0, "rst_rpe");
    push(cyc, F_RDY, 1, "rst_ready");
    push(cyc, F_BSY, 0, "rst_busy");
    goto(cyc + 2);

    // reward 200 from expectation 0: max burst, then high decay
    t = cyc;
    push(t + 1, F_RDY, 0, "r200_ready_eval");
    push(t + 1, F_LVL, 1, "r200_level_eval");
    push(t + 2, F_RPE, 200, "r200_rpe");
    push(t + 2, F_EXP, 50, "r200_expected");
    push_lvl(t + 2, t + 5, 3, "r200_level_max");
    push_lvl(t + 6, t + 9, 2, "r200_level_high");
    push(t + 9, F_BSY, 1, "r200_busy_decay");
    push(t + 10, F_LVL, 1, "r200_level_base");
    push(t + 10, F_BSY, 0, "r200_busy_done");
    send(8'd200, 1'b0, t);
    goto(t + 12);

    // reward 50 against expectation 50: no burst
    t = cyc;
    push(t + 1, F_BSY, 1, "r50_busy_eval");
    push_lvl(t + 1, t + 4, 1, "r50_level");
    push(t + 2, F_RPE, 0, "r50_rpe");
    push(t + 2, F_EXP, 50, "r50_expected");
    push(t + 2, F_BSY, 0, "r50_idle");
    send(8'd50, 1'b0, t);
    goto(t + 6);

    // reward 0 against expectation 50: dip then baseline
    t = cyc;
    push(t + 2, F_RPE, -50, "r0_rpe");
    push(t + 2, F_EXP, 37, "r0_expected_floor");
    push_lvl(t + 2, t + 5, 0, "r0_level_none");
    push(t + 6, F_LVL, 1, "r0_level_base");
    push(t + 6, F_BSY, 0, "r0_busy_done");
    send(8'd0, 1'b0, t);
    goto(t + 8);

    // expect_clr during EVAL: expectation cleared, level still follows rpe=163
    t = cyc;
    push(t + 2, F_RPE, 163, "clr_rpe");
    push(t + 2, F_EXP, 0, "clr_expected");
    push_lvl(t + 2, t + 5, 3, "clr_level_max");
    push(t + 6, F_LVL, 2, "clr_level_high");
    send(8'd200, 1'b1, t);
    goto(t + 12);

    // rebuild expectation 50, then reward 0 preempted at T+3 by reward 255
    t = cyc;
    push(t + 2, F_EXP, 50, "re50_expected");
    send(8'd200, 1'b0, t);
    goto(t + 12);
    t = cyc;
    push_lvl(t + 2, t + 3, 0, "pre_level_dip");
    push(t + 2, F_EXP, 37, "pre_expected_first");
    push(t + 4, F_LVL, 1, "pre_level_eval");
    push(t + 4, F_RDY, 0, "pre_ready_eval");
    push(t + 5, F_RPE, 218, "pre_rpe");
    push(t + 5, F_EXP, 91, "pre_expected");
    push_lvl(t + 5, t + 8, 3, "pre_level_max");
    push_lvl(t + 9, t + 12, 2, "pre_level_high");
    push(t + 13, F_LVL, 1, "pre_level_base");
    send(8'd0, 1'b0, t);
    goto(t + 3);
    send(8'd255, 1'b0, t2);
    goto(t + 15);

    // reset asserted mid-decay
    t = cyc;
    push(t + 2, F_RPE, 109, "rstd_rpe");
    push(t + 7, F_LVL, 2, "rstd_level_decay");
    push(t + 7, F_BSY, 1, "rstd_busy_decay");
    push(t + 8, F_LVL, 1, "rstd_level_base");
    push(t + 8, F_RDY, 1, "rstd_ready");
    push(t + 8, F_BSY, 0, "rstd_busy");
    push(t + 8, F_EXP, 0, "rstd_expected");
    push(t + 8, F_RPE, 0, "rstd_rpe_clr");
    send(8'd200, 1'b0, t);
    goto(t + 7);
    rst = 1'b1;
    goto(t + 8);
    rst = 1'b0;
    goto(t + 10);

    // TH_LOW boundary: rpe 16 gives one high hold, rpe 15 gives nothing
    t = cyc;
    push(t + 2, F_RPE, 16, "th16_rpe");
    push_lvl(t + 2, t + 5, 2, "th16_level_high");
    push(t + 6, F_LVL, 1, "th16_level_base");
    push(t + 6, F_BSY, 0, "th16_busy_done");
    push(t + 2, F_EXP, 4, "th16_expected");
    send(8'd16, 1'b0, t);
    goto(t + 8);
    t = cyc;
    push(t + 2, F_RPE, 15, "th15_rpe");
    push(t + 2, F_LVL, 1, "th15_level");
    push(t + 2, F_BSY, 0, "th15_idle");
    push(t + 2, F_EXP, 7, "th15_expected");
    send(8'd19, 1'b0, t);
    goto(t + 5);

    if (sb.size() != 0) begin
      n_bad += sb.size();
      $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d want=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
